// File: rtl/game_sequencer.sv
// game_sequencer: frame/round sequencer running NUM_LAYERS one-hot draw handshakes, a round count and lives.
// Optional GAME_SEQ_PAUSE_EN adds pause/paused, which freeze the ANIM state.
module game_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int LIVES      = 3,
  parameter int ROUND_W    = 8,
  parameter int LIVES_W    = $clog2(LIVES + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic                  pause,
  output logic                  paused,
`endif
  output logic                  ld_clear,
  input  logic                  clear_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  ld_coord,
  output logic                  ld_plot,
  input  logic                  anim_done,
  input  logic                  miss,
  output logic [ROUND_W-1:0]    round,
  output logic [LIVES_W-1:0]    lives_left,
  output logic                  ld_gameover,
  output logic                  busy,
  output logic [2:0]            state_dbg
);
  localparam int IW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_LAYERS - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, CLEAR = 3'd1, LAYER = 3'd2, COORD = 3'd3, ANIM = 3'd4, GAMEOVER = 3'd5} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 hold, issue;
`ifdef GAME_SEQ_PAUSE_EN
  logic                 paused_q;
  assign hold   = pause;
  assign paused = paused_q;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    round_d = round_q;
    lives_d = lives_q;
    case (state_q)
      IDLE, GAMEOVER: if (start) begin
        state_d = CLEAR;
        round_d = '0;
        lives_d = LIVES_W'(LIVES);
      end
      CLEAR: if (clear_done) begin
        state_d = LAYER;
        idx_d   = '0;
      end
      LAYER: if (layer_done[idx_q]) begin
        state_d = idx_q == LAST ? COORD : LAYER;
        idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
      end
      COORD: state_d = ANIM;
      ANIM: if (!hold && (miss || anim_done)) begin
        // miss has priority over a simultaneous hit
        state_d = miss && lives_q == LIVES_W'(1) ? GAMEOVER : LAYER;
        idx_d   = '0;
        lives_d = miss ? lives_q - 1'b1 : lives_q;
        round_d = !miss && !(&round_q) ? round_q + 1'b1 : round_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // a pulse is due on entry to LAYER and whenever a non-final pass is accepted
  assign issue = state_d == LAYER && (state_q != LAYER || layer_done[idx_q]);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      round_q     <= '0;
      lives_q     <= LIVES_W'(LIVES);
      ld_clear    <= 1'b0;
      layer_start <= '0;
      ld_coord    <= 1'b0;
      ld_plot     <= 1'b0;
      ld_gameover <= 1'b0;
      busy        <= 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      paused_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      round_q     <= round_d;
      lives_q     <= lives_d;
      ld_clear    <= state_d == CLEAR;
      layer_start <= issue ? NUM_LAYERS'(1) << idx_d : '0;
      ld_coord    <= state_d == COORD;
      ld_plot     <= state_d == ANIM && !hold;
      ld_gameover <= state_d == GAMEOVER;
      busy        <= state_d != IDLE && state_d != GAMEOVER;
`ifdef GAME_SEQ_PAUSE_EN
      paused_q    <= state_d == ANIM && hold;
`endif
    end
  end
  assign round      = round_q;
  assign lives_left = lives_q;
  assign state_dbg  = state_q;
endmodule
